// File: rtl/vliw_pkg.sv
// Shared types and constants for the VLIW fetch stage: instruction width, NOP encoding,
// bundle layout (slot 0 in the low word) and the prefetch FIFO entry.
package vliw_pkg;

  localparam int INST_W    = 32;
  localparam int NUM_SLOTS = 2;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef logic [NUM_SLOTS-1:0][INST_W-1:0] bundle_t;

  typedef struct packed {
    logic [31:0] pc;
    bundle_t     bundle;
  } fifo_entry_t;

  localparam bundle_t NOP_BUNDLE = {NUM_SLOTS{NOP_INST}};

endpackage

// File: rtl/vliw_fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, bundle} entries with a clear input that has
// priority over push; DEPTH must be a power of two so the pointers wrap naturally.
module vliw_fetch_fifo
  import vliw_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  fifo_entry_t              wdata,
  output fifo_entry_t              rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(DEPTH);

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_L);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is left unreset; count/pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/vliw_fetch.sv
// VLIW fetch/issue stage: credit-limited bundle requests, prefetch FIFO, instruction register
// and branch redirect/squash. Define VLIW_FETCH_PERF_EN to enable the perf counters.
module vliw_fetch
  import vliw_pkg::*;
#(
  parameter int          SLOTS      = NUM_SLOTS,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic [31:0]             branch_target,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [31:0]             imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [SLOTS*INST_W-1:0] imem_rsp_data,
  output logic [SLOTS*INST_W-1:0] issue_inst,
  output logic [31:0]             issue_pc,
  output logic                    branch_squash,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_bubble_cnt,
  output logic [31:0]             perf_flush_cnt
);

  localparam int               CNT_W        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_LIM    = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [31:0]      BUNDLE_BYTES = 32'(SLOTS * 4);

  logic [31:0]      pc_q, pc_d, rsp_pc_q, rsp_pc_d, issue_pc_q, issue_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d, drop_q, drop_d;
  bundle_t          ir_q, ir_d;

  logic             fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  fifo_entry_t      fifo_head, fifo_wdata;
  logic             req_accept;

  assign fifo_wdata     = '{pc: rsp_pc_q, bundle: imem_rsp_data};
  assign imem_req_valid = !rst && !branch_taken &&
                          (({1'b0, fifo_count} + {1'b0, outstanding_q}) < DEPTH_LIM);
  assign imem_req_addr  = pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign branch_squash  = branch_taken;
  assign issue_inst     = ir_q;
  assign issue_pc       = issue_pc_q;

  vliw_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (branch_taken),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    ir_d          = ir_q;
    issue_pc_d    = issue_pc_q;
    fifo_push     = 1'b0;
    fifo_pop      = 1'b0;
    if (req_accept) begin
      pc_d          = pc_q + BUNDLE_BYTES;
      outstanding_d = outstanding_q + CNT_ONE;
    end
    // rsp_pc tracks the address of the next live response, so it skips dropped ones.
    if (imem_rsp_valid) begin
      outstanding_d = outstanding_d - CNT_ONE;
      if (drop_q != '0) begin
        drop_d = drop_q - CNT_ONE;
      end else if (!branch_taken) begin
        fifo_push = 1'b1;
        rsp_pc_d  = rsp_pc_q + BUNDLE_BYTES;
      end
    end
    if (branch_taken) begin
      pc_d     = branch_target;
      rsp_pc_d = branch_target;
      drop_d   = outstanding_d;
      ir_d     = NOP_BUNDLE;
    end else if (!stall) begin
      if (fifo_empty) begin
        ir_d = NOP_BUNDLE;
      end else begin
        ir_d       = fifo_head.bundle;
        issue_pc_d = fifo_head.pc;
        fifo_pop   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
      ir_q          <= NOP_BUNDLE;
      issue_pc_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      ir_q          <= ir_d;
      issue_pc_q    <= issue_pc_d;
    end
  end

`ifdef VLIW_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d  = perf_fetch_q;
    perf_bubble_d = perf_bubble_q;
    perf_flush_d  = perf_flush_q;
    if (branch_taken)     perf_flush_d  = perf_flush_q + 32'd1;
    else if (fifo_pop)    perf_fetch_d  = perf_fetch_q + 32'd1;
    else if (!stall)      perf_bubble_d = perf_bubble_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
      perf_flush_q  <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt  = perf_fetch_q;
  assign perf_bubble_cnt = perf_bubble_q;
  assign perf_flush_cnt  = perf_flush_q;
`else
  assign perf_fetch_cnt  = 32'h0;
  assign perf_bubble_cnt = 32'h0;
  assign perf_flush_cnt  = 32'h0;
`endif

endmodule

// File: tb/tb_vliw_fetch.sv
// Self-checking bench for vliw_fetch: in-order latency memory model plus a queue-based
// reference of the fetch stream, directed scenarios, then randomized stimulus.
module tb_vliw_fetch;
  import vliw_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [63:0] NOPB  = 64'h0000_0013_0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, imem_req_ready, imem_rsp_valid;
  logic [31:0] branch_target, imem_req_addr, issue_pc;
  logic        imem_req_valid, branch_squash;
  logic [63:0] imem_rsp_data, issue_inst;
  logic [31:0] perf_fetch_cnt, perf_bubble_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  vliw_fetch #(.SLOTS(2), .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .issue_inst     (issue_inst),
    .issue_pc       (issue_pc),
    .branch_squash  (branch_squash),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_bubble_cnt(perf_bubble_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Memory contents: word at byte address a is a ^ 0xC000_0000 (never the NOP encoding).
  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return {(a + 32'd4) ^ 32'hC000_0000, a ^ 32'hC000_0000};
  endfunction

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] addr; bit stale; } flight_t;

  pend_t       pend[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat = 1;

  flight_t     inflight[$];
  logic [31:0] mq[$];
  logic [31:0] m_pc = 32'h0;
  bit          ir_nop = 1'b1;
  logic [31:0] ir_pc = 32'h0;
  int          c_fetch = 0, c_bubble = 0, c_flush = 0;

  logic        s_rst = 1'b1, s_stall = 1'b0, s_br = 1'b0, s_ready = 1'b1;
  logic [31:0] s_tgt = 32'h0;
  logic        last_rv;
  logic [31:0] last_addr;

  task automatic step();
    bit          rsp_now, exp_rv;
    logic [31:0] rsp_addr;
    flight_t     e;
    int          due;
    @(negedge clk);
    rst            = s_rst;
    stall          = s_stall;
    branch_taken   = s_br;
    branch_target  = s_tgt;
    imem_req_ready = s_ready;
    rsp_now  = 1'b0;
    rsp_addr = 32'h0;
    if (!s_rst && pend.size() > 0 && pend[0].due <= cyc) begin
      rsp_now  = 1'b1;
      rsp_addr = pend.pop_front().addr;
    end
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? mem_data(rsp_addr) : 64'h0;
    #1;
    last_rv   = imem_req_valid;
    last_addr = imem_req_addr;
    exp_rv = !s_rst && !s_br && ((mq.size() + inflight.size()) < DEPTH);
    check("req_valid", {63'h0, imem_req_valid}, {63'h0, exp_rv});
    if (exp_rv) check("req_addr", {32'h0, imem_req_addr}, {32'h0, m_pc});
    check("squash", {63'h0, branch_squash}, {63'h0, s_br});
    @(posedge clk);
    if (s_rst) begin
      pend.delete();
      last_due = cyc;
      inflight.delete();
      mq.delete();
      m_pc = 32'h0; ir_nop = 1'b1; ir_pc = 32'h0;
      c_fetch = 0; c_bubble = 0; c_flush = 0;
    end else begin
      if (last_rv && s_ready) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        last_due = due;
        pend.push_back('{addr: last_addr, due: due});
      end
      e = '{addr: 32'h0, stale: 1'b1};
      if (rsp_now && inflight.size() > 0) e = inflight.pop_front();
      if (s_br) begin
        ir_nop = 1'b1;
        mq.delete();
        foreach (inflight[k]) inflight[k].stale = 1'b1;
        m_pc = s_tgt;
        c_flush++;
      end else begin
        if (!s_stall) begin
          if (mq.size() > 0) begin
            ir_pc  = mq.pop_front();
            ir_nop = 1'b0;
            c_fetch++;
          end else begin
            ir_nop = 1'b1;
            c_bubble++;
          end
        end
        if (rsp_now && !e.stale) mq.push_back(e.addr);
      end
      if (exp_rv && s_ready) begin
        inflight.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd8;
      end
    end
    cyc++;
    #1;
    check("issue_inst", issue_inst, ir_nop ? NOPB : mem_data(ir_pc));
    if (!ir_nop) check("issue_pc", {32'h0, issue_pc}, {32'h0, ir_pc});
`ifdef VLIW_FETCH_PERF_EN
    check("perf_fetch", {32'h0, perf_fetch_cnt}, 64'(c_fetch));
    check("perf_bubble", {32'h0, perf_bubble_cnt}, 64'(c_bubble));
    check("perf_flush", {32'h0, perf_flush_cnt}, 64'(c_flush));
`else
    check("perf_zero", {perf_fetch_cnt, perf_bubble_cnt | perf_flush_cnt}, 64'h0);
`endif
  endtask

  initial begin
    bit          found;
    logic [63:0] held_inst;
    logic [31:0] held_pc;
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 64'h0;

    // 1: reset, latency 1, ready=1
    s_rst = 1'b1; step(); step();
    check("t1_reset_inst", issue_inst, NOPB);
    check("t1_reset_pc", {32'h0, issue_pc}, 64'h0);
    s_rst = 1'b0; lat = 1; s_ready = 1'b1;
    step(); check("t1_addr0", {32'h0, last_addr}, 64'h0);
    step(); check("t1_addr1", {32'h0, last_addr}, 64'h8);
    check("t1_ir_bubble", issue_inst, NOPB);
    step(); check("t1_addr2", {32'h0, last_addr}, 64'h10);
    check("t1_first_inst", issue_inst, 64'hC000_0004_C000_0000);
    check("t1_first_pc", {32'h0, issue_pc}, 64'h0);
    repeat (6) step();

    // 2: stall 5 cycles while the FIFO fills
    held_inst = issue_inst; held_pc = issue_pc;
    s_stall = 1'b1;
    repeat (5) step();
    check("t2_ir_held", issue_inst, held_inst);
    check("t2_pc_held", {32'h0, issue_pc}, {32'h0, held_pc});
    check("t2_credit_stop", {63'h0, last_rv}, 64'h0);
    s_stall = 1'b0;
    repeat (10) step();

    // 3: latency 3, three outstanding, redirect to 0x100
    lat = 3;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (inflight.size() == 3) found = 1'b1;
      else step();
    end
    if (!found) timeout("t3_three_outstanding");
    s_br = 1'b1; s_tgt = 32'h100; step(); s_br = 1'b0;
    check("t3_ir_nop", issue_inst, NOPB);
    step();
    check("t3_new_req_valid", {63'h0, last_rv}, 64'h1);
    check("t3_new_req_addr", {32'h0, last_addr}, 64'h100);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (!ir_nop) found = 1'b1;
    end
    if (!found) timeout("t3_first_new_issue");
    check("t3_first_pc", {32'h0, issue_pc}, 64'h100);
    check("t3_first_inst", issue_inst, 64'hC000_0104_C000_0100);

    // 4: redirect during stall with a response arriving the same cycle
    lat = 2;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (pend.size() > 0 && pend[0].due <= cyc) found = 1'b1;
      else step();
    end
    if (!found) timeout("t4_rsp_due");
    s_stall = 1'b1; s_br = 1'b1; s_tgt = 32'h200; step();
    s_stall = 1'b0; s_br = 1'b0;
    check("t4_ir_nop", issue_inst, NOPB);
    step();
    check("t4_fifo_empty_bubble", issue_inst, NOPB);
    repeat (8) step();

    // 5: memory not ready for 10 cycles: drain, bubbles, pc frozen
    held_pc = m_pc;
    s_ready = 1'b0;
    repeat (10) step();
    check("t5_pc_frozen", {32'h0, last_addr}, {32'h0, held_pc});
    check("t5_bubble", issue_inst, NOPB);
    s_ready = 1'b1;
    repeat (6) step();

    // 6: reset with a full FIFO
    lat = 1; s_stall = 1'b1;
    repeat (6) step();
    s_rst = 1'b1; s_stall = 1'b0; step();
    check("t6_inst", issue_inst, NOPB);
    check("t6_pc", {32'h0, issue_pc}, 64'h0);
    check("t6_req_in_reset", {63'h0, last_rv}, 64'h0);
    s_rst = 1'b0; step();
    check("t6_addr", {32'h0, last_addr}, 64'h0);

    // Randomized traffic, including redirects near the 2^32 wrap
    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(0, 499) == 0);
      s_stall = ($urandom_range(0, 9) < 3);
      s_br    = !s_br && !s_rst && ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 2))
        0:       s_tgt = $urandom & 32'hFFFF_FFF8;
        1:       s_tgt = 32'hFFFF_FFE8;
        default: s_tgt = 32'h0000_0100;
      endcase
      s_ready = ($urandom_range(0, 9) < 7);
      lat     = $urandom_range(1, 4);
      step();
    end
    s_br = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
